// File: rtl/ama_riscv_fetch_if.sv
// ama_riscv_fetch_if: instruction-memory read port between fetch (master) and IMEM (slave)
interface ama_riscv_fetch_if;
    logic [13:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, output imem_en, input imem_rdata);
    modport slave  (input imem_addr, input imem_en, output imem_rdata);
endinterface

// File: rtl/ama_riscv_fetch.sv
// ama_riscv_fetch: IF stage with PC select, synchronous IMEM read, bubble injection and counters
module ama_riscv_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP          = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               pc_sel,
    input  logic                     pc_we,
    input  logic [31:0]              alu_out,
    input  logic                     stall_if,
    input  logic                     clear_if,
    ama_riscv_fetch_if.master        imem,
    output logic [31:0]              pc_id,
    output logic [31:0]              pc_id_plus4,
    output logic [31:0]              inst_id,
    output logic                     inst_id_valid,
    output logic [31:0]              cnt_fetch,
    output logic [31:0]              cnt_bubble
);
    localparam logic [1:0] SEL_INC4 = 2'd0;
    localparam logic [1:0] SEL_ALU  = 2'd1;
    localparam logic [1:0] SEL_BP   = 2'd2;

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_next;
    logic        kill_q, kill_d;
    logic [31:0] cnt_fetch_q, cnt_fetch_d;
    logic [31:0] cnt_bubble_q, cnt_bubble_d;
    logic        run;

    // State registers; reset discards every in-flight fetch, stall and pending jump
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            kill_q       <= 1'b1;
            cnt_fetch_q  <= '0;
            cnt_bubble_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            cnt_fetch_q  <= cnt_fetch_d;
            cnt_bubble_q <= cnt_bubble_d;
        end
    end

    // Next-state, next-PC, IMEM request and ID-stage outputs
    always_comb begin
        state_d       = RUN;
        run           = (state_q == RUN);
        pc_next       = pc_q + 32'd4;
        if (pc_sel == SEL_ALU)
            pc_next = alu_out & 32'hFFFF_FFFC;
        else if (pc_sel != SEL_INC4 && pc_sel != SEL_BP)
            pc_next = RESET_VECTOR;
        pc_d          = !run ? RESET_VECTOR : (pc_we ? pc_next : pc_q);
        // The RESET_VECTOR read issued during BOOT is a real fetch, so it is never killed
        kill_d        = run & (stall_if | clear_if);
        inst_id_valid = run & ~kill_q;
        inst_id       = inst_id_valid ? imem.imem_rdata : NOP;
        cnt_fetch_d   = cnt_fetch_q + {31'd0, inst_id_valid};
        cnt_bubble_d  = cnt_bubble_q + {31'd0, run & ~inst_id_valid};
        // Without a PC write the current address is re-read so imem_rdata stays put
        imem.imem_addr = !run ? RESET_VECTOR[15:2] : (pc_we ? pc_next[15:2] : pc_q[15:2]);
        imem.imem_en   = rst_n;
        pc_id          = pc_q;
        pc_id_plus4    = pc_q + 32'd4;
        cnt_fetch      = cnt_fetch_q;
        cnt_bubble     = cnt_bubble_q;
    end
endmodule

// File: tb/tb_ama_riscv_fetch.sv
// tb_ama_riscv_fetch: directed self-checking bench for the fetch stage
module tb_ama_riscv_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_sel;
    logic        pc_we;
    logic [31:0] alu_out;
    logic        stall_if;
    logic        clear_if;
    logic [31:0] pc_id, pc_id_plus4, inst_id, cnt_fetch, cnt_bubble;
    logic        inst_id_valid;
    int          checks = 0;
    int          errors = 0;

    ama_riscv_fetch_if bus ();

    ama_riscv_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_sel        (pc_sel),
        .pc_we         (pc_we),
        .alu_out       (alu_out),
        .stall_if      (stall_if),
        .clear_if      (clear_if),
        .imem          (bus),
        .pc_id         (pc_id),
        .pc_id_plus4   (pc_id_plus4),
        .inst_id       (inst_id),
        .inst_id_valid (inst_id_valid),
        .cnt_fetch     (cnt_fetch),
        .cnt_bubble    (cnt_bubble)
    );

    always #5 clk = ~clk;

    // IMEM model: word i holds 0x13 + (i << 7), one-cycle synchronous read
    always @(posedge clk) begin
        if (bus.imem_en)
            bus.imem_rdata <= 32'h0000_0013 + ({18'd0, bus.imem_addr} << 7);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] inst, input logic v);
        chk({tag, "_pc"}, pc_id, pc);
        chk({tag, "_inst"}, inst_id, inst);
        chk({tag, "_valid"}, {31'd0, inst_id_valid}, {31'd0, v});
    endtask

    initial begin
        rst_n = 1'b0; pc_sel = 2'd0; pc_we = 1'b1; alu_out = '0; stall_if = 1'b0; clear_if = 1'b0;
        #12;
        chk_id("rst", 32'h0, 32'h13, 1'b0);
        chk("rst_plus4", pc_id_plus4, 32'h4);
        chk("rst_cntf", cnt_fetch, 32'h0);
        chk("rst_cntb", cnt_bubble, 32'h0);
        chk("rst_en", {31'd0, bus.imem_en}, 32'h0);
        // release reset: one BOOT cycle
        @(negedge clk); rst_n = 1'b1; #1;
        chk_id("boot", 32'h0, 32'h13, 1'b0);
        chk("boot_en", {31'd0, bus.imem_en}, 32'h1);
        chk("boot_addr", {18'd0, bus.imem_addr}, 32'h0);
        // sequential fetch
        @(negedge clk); chk_id("seq0", 32'h0, 32'h13, 1'b1);
        chk("seq0_cntb", cnt_bubble, 32'h0);
        @(negedge clk); chk_id("seq4", 32'h4, 32'h93, 1'b1);
        @(negedge clk); chk_id("seq8", 32'h8, 32'h113, 1'b1);
        @(negedge clk); chk_id("seqc", 32'hC, 32'h193, 1'b1);
        @(negedge clk); chk_id("seq10", 32'h10, 32'h213, 1'b1);
        chk("seq10_cntf", cnt_fetch, 32'd4);
        // stall at 0x10
        stall_if = 1'b1; pc_we = 1'b0; #1;
        chk("stall_addr", {18'd0, bus.imem_addr}, 32'h4);
        @(negedge clk); chk_id("stall", 32'h10, 32'h13, 1'b0);
        chk("stall_cntb", cnt_bubble, 32'd0);
        stall_if = 1'b0; pc_we = 1'b1;
        @(negedge clk); chk_id("post_stall", 32'h14, 32'h293, 1'b1);
        chk("stall_cntb1", cnt_bubble, 32'd1);
        chk("stall_cntf", cnt_fetch, 32'd5);
        // jump to 0x103 -> 0x100
        pc_sel = 2'd1; alu_out = 32'h0000_0103; #1;
        chk("jmp_addr", {18'd0, bus.imem_addr}, 32'h40);
        @(negedge clk); chk_id("jmp", 32'h100, 32'h2013, 1'b1);
        chk("jmp_plus4", pc_id_plus4, 32'h104);
        // stall and clear together
        pc_sel = 2'd0; pc_we = 1'b0; stall_if = 1'b1; clear_if = 1'b1;
        @(negedge clk); chk_id("both", 32'h100, 32'h13, 1'b0);
        stall_if = 1'b0; clear_if = 1'b0; pc_we = 1'b1;
        @(negedge clk); chk_id("post_both", 32'h104, 32'h2093, 1'b1);
        chk("both_cntb", cnt_bubble, 32'd2);
        chk("both_cntf", cnt_fetch, 32'd7);
        // jump while kill_q is set, to 0xFFFFFFFC
        stall_if = 1'b1; pc_we = 1'b0;
        @(negedge clk); chk_id("kill", 32'h104, 32'h13, 1'b0);
        stall_if = 1'b0; pc_we = 1'b1; pc_sel = 2'd1; alu_out = 32'hFFFF_FFFC;
        @(negedge clk); chk_id("top", 32'hFFFF_FFFC, 32'h001F_FF93, 1'b1);
        chk("top_plus4", pc_id_plus4, 32'h0);
        chk("top_cntb", cnt_bubble, 32'd3);
        chk("top_cntf", cnt_fetch, 32'd8);
        // wrap PC, and wrap cnt_fetch
        pc_sel = 2'd0;
        force dut.cnt_fetch_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_fetch_q;
        @(negedge clk); chk_id("wrap", 32'h0, 32'h13, 1'b1);
        chk("wrap_plus4", pc_id_plus4, 32'h4);
        chk("wrap_cntf", cnt_fetch, 32'h0);
        // START_ADDR select
        pc_sel = 2'd3;
        @(negedge clk); chk_id("start", 32'h0, 32'h13, 1'b1);
        // BP select behaves as INC4
        pc_sel = 2'd2;
        @(negedge clk); chk_id("bp", 32'h4, 32'h93, 1'b1);
        // async reset mid-cycle during a jump
        pc_sel = 2'd1; alu_out = 32'h0000_0200;
        @(posedge clk); #2; rst_n = 1'b0; #1;
        chk_id("arst", 32'h0, 32'h13, 1'b0);
        chk("arst_plus4", pc_id_plus4, 32'h4);
        chk("arst_cntf", cnt_fetch, 32'h0);
        chk("arst_cntb", cnt_bubble, 32'h0);
        chk("arst_en", {31'd0, bus.imem_en}, 32'h0);
        @(negedge clk); rst_n = 1'b1; pc_sel = 2'd0; #1;
        chk_id("reboot", 32'h0, 32'h13, 1'b0);
        @(negedge clk); chk_id("rerun0", 32'h0, 32'h13, 1'b1);
        @(negedge clk); chk_id("rerun4", 32'h4, 32'h93, 1'b1);
        chk("rerun_cntf", cnt_fetch, 32'd1);
        chk("rerun_cntb", cnt_bubble, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
